sram_port0_arbiter: RTL and testbench

SRAM_PORT0_ARBITER -- requirements
Module: sram_port0_arbiter

---
 rtl/sram_port0_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sram_port0_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port0_arbiter.sv
// Round-robin arbiter sharing SRAM port 0 between two requesters, two-cycle response latency.
// Define SRAM_INIT_EN to zero-fill the whole array after every reset before accepting requests.
module sram_port0_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WMASKS = 4
) (
    input  logic                  clk0,
    input  logic                  rst0,

    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic                  r0_we,
    input  logic [NUM_WMASKS-1:0] r0_wmask,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_rsp_valid,

    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic                  r1_we,
    input  logic [NUM_WMASKS-1:0] r1_wmask,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_rsp_valid,

    output logic [DATA_WIDTH-1:0] rsp_rdata,

    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,

    output logic                  init_done
);

    logic                  arb_en;
    logic                  in_init;
    logic [ADDR_WIDTH-1:0] init_addr;

    logic                  gnt0;
    logic                  gnt1;
    logic                  accept;
    logic                  sel_we;
    logic [NUM_WMASKS-1:0] sel_wmask;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // prio_q = 1 gives requester 1 the win on contention
    logic                  prio_q;
    logic                  prio_d;
    logic                  pend_valid_q;
    logic                  pend_id_q;
    logic                  pend_we_q;
    logic                  rsp_valid_q;
    logic                  rsp_id_q;
    logic [DATA_WIDTH-1:0] rdata_q;

`ifdef SRAM_INIT_EN
    typedef enum logic [0:0] {StInit, StArb} state_e;

    state_e                state_q;
    state_e                state_d;
    logic [ADDR_WIDTH-1:0] init_addr_q;
    logic [ADDR_WIDTH-1:0] init_addr_d;

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state_q     <= StInit;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        if (state_q == StInit) begin
            init_addr_d = init_addr_q + ADDR_WIDTH'(1);
            if (init_addr_q == '1) begin
                state_d = StArb;
            end
        end
    end

    assign in_init   = (state_q == StInit) && !rst0;
    assign arb_en    = (state_q == StArb) && !rst0;
    assign init_addr = init_addr_q;
    assign init_done = (state_q == StArb);
`else
    assign in_init   = 1'b0;
    assign arb_en    = !rst0;
    assign init_addr = '0;
    assign init_done = 1'b1;
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (arb_en) begin
            if (r0_valid && (!r1_valid || !prio_q)) begin
                gnt0 = 1'b1;
            end else if (r1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign accept    = gnt0 | gnt1;
    assign r0_ready  = gnt0;
    assign r1_ready  = gnt1;

    assign sel_we    = gnt1 ? r1_we    : r0_we;
    assign sel_wmask = gnt1 ? r1_wmask : r0_wmask;
    assign sel_addr  = gnt1 ? r1_addr  : r0_addr;
    assign sel_wdata = gnt1 ? r1_wdata : r0_wdata;

    // Winner loses priority so the other requester wins the next contention
    assign prio_d = gnt0 ? 1'b1 : (gnt1 ? 1'b0 : prio_q);

    always_comb begin
        csb0   = 1'b1;
        web0   = 1'b1;
        wmask0 = '0;
        addr0  = '0;
        din0   = '0;
        if (in_init) begin
            csb0   = 1'b0;
            web0   = 1'b0;
            wmask0 = '1;
            addr0  = init_addr;
        end else if (accept) begin
            csb0   = 1'b0;
            web0   = ~sel_we;
            wmask0 = sel_we ? sel_wmask : '0;
            addr0  = sel_addr;
            din0   = sel_wdata;
        end
    end

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            prio_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_id_q    <= 1'b0;
            pend_we_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            prio_q       <= prio_d;
            pend_valid_q <= accept;
            pend_id_q    <= gnt1;
            pend_we_q    <= sel_we;
            rsp_valid_q  <= pend_valid_q;
            rsp_id_q     <= pend_id_q;
            // dout0 settles after the falling edge following the access edge
            if (pend_valid_q && !pend_we_q) begin
                rdata_q <= dout0;
            end
        end
    end

    assign r0_rsp_valid = rsp_valid_q && !rsp_id_q;
    assign r1_rsp_valid = rsp_valid_q && rsp_id_q;
    assign rsp_rdata    = rdata_q;

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Bench for sram_port0_arbiter: SRAM macro model, per-cycle reference model, directed and random stimulus.
module tb_sram_port0_arbiter;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int NM    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int LW    = DW / NM;
`ifdef SRAM_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic          clk0 = 1'b0;
    logic          rst0 = 1'b1;
    logic          r0_valid, r0_ready, r0_we, r0_rsp_valid;
    logic [NM-1:0] r0_wmask;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r1_valid, r1_ready, r1_we, r1_rsp_valid;
    logic [NM-1:0] r1_wmask;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic [DW-1:0] rsp_rdata;
    logic          csb0, web0;
    logic [NM-1:0] wmask0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0;
    logic          init_done;

    int errors = 0;
    int checks = 0;

    always #5 clk0 = ~clk0;

    sram_port0_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUM_WMASKS(NM)
    ) dut (
        .clk0        (clk0),
        .rst0        (rst0),
        .r0_valid    (r0_valid),
        .r0_ready    (r0_ready),
        .r0_we       (r0_we),
        .r0_wmask    (r0_wmask),
        .r0_addr     (r0_addr),
        .r0_wdata    (r0_wdata),
        .r0_rsp_valid(r0_rsp_valid),
        .r1_valid    (r1_valid),
        .r1_ready    (r1_ready),
        .r1_we       (r1_we),
        .r1_wmask    (r1_wmask),
        .r1_addr     (r1_addr),
        .r1_wdata    (r1_wdata),
        .r1_rsp_valid(r1_rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .csb0        (csb0),
        .web0        (web0),
        .wmask0      (wmask0),
        .addr0       (addr0),
        .din0        (din0),
        .dout0       (dout0),
        .init_done   (init_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM macro: pins captured at the rising edge, array access on the following falling edge
    logic [DW-1:0] sram    [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic          sp_v, sp_we;
    logic [NM-1:0] sp_mask;
    logic [AW-1:0] sp_addr;
    logic [DW-1:0] sp_din;

    always @(negedge clk0) begin
        if (sp_v) begin
            if (sp_we) begin
                for (int l = 0; l < NM; l++)
                    if (sp_mask[l]) sram[sp_addr][l*LW +: LW] = sp_din[l*LW +: LW];
            end else begin
                dout0 = sram[sp_addr];
            end
        end
        sp_v    = (csb0 === 1'b0);
        sp_we   = (web0 === 1'b0);
        sp_mask = wmask0;
        sp_addr = addr0;
        sp_din  = din0;
    end

    // Reference model: per-cycle expectation from the request-level rules
    typedef struct {
        bit            v;
        bit            id;
        bit            we;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          st1, st2;
    int            m_last;
    int            m_init_cnt;
    logic [DW-1:0] m_rdata;

    always @(negedge clk0) begin
        bit            e_r0, e_r1, e_csb, e_web, e_done, e_p0, e_p1, q_we;
        logic [NM-1:0] e_mask, q_mask;
        logic [AW-1:0] e_addr, q_addr;
        logic [DW-1:0] e_din, q_data;
        int            win;
        e_r0 = 0; e_r1 = 0; e_csb = 1; e_web = 1; e_done = 1; e_p0 = 0; e_p1 = 0;
        e_mask = '0; e_addr = '0; e_din = '0; win = -1;
        if (rst0) begin
            m_last     = 1;
            m_init_cnt = 0;
            m_rdata    = '0;
            st1        = '{default: 0};
            st2        = '{default: 0};
            e_done     = !INIT_EN;
        end else begin
            e_p0 = st2.v && (st2.id == 1'b0);
            e_p1 = st2.v && (st2.id == 1'b1);
            if (st2.v && !st2.we) m_rdata = st2.data;
            st2 = st1;
            st1 = '{default: 0};
            if (INIT_EN && m_init_cnt < DEPTH) begin
                e_done = 0; e_csb = 0; e_web = 0; e_mask = '1;
                e_addr = AW'(m_init_cnt);
                ref_mem[m_init_cnt] = '0;
                m_init_cnt++;
            end else begin
                if (r0_valid && r1_valid) win = (m_last == 0) ? 1 : 0;
                else if (r0_valid)        win = 0;
                else if (r1_valid)        win = 1;
                if (win >= 0) begin
                    q_we   = (win == 0) ? r0_we    : r1_we;
                    q_mask = (win == 0) ? r0_wmask : r1_wmask;
                    q_addr = (win == 0) ? r0_addr  : r1_addr;
                    q_data = (win == 0) ? r0_wdata : r1_wdata;
                    e_r0   = (win == 0);
                    e_r1   = (win == 1);
                    e_csb  = 0;
                    e_web  = !q_we;
                    e_mask = q_we ? q_mask : '0;
                    e_addr = q_addr;
                    e_din  = q_data;
                    st1.v    = 1;
                    st1.id   = (win == 1);
                    st1.we   = q_we;
                    st1.data = ref_mem[q_addr];
                    if (q_we)
                        for (int l = 0; l < NM; l++)
                            if (q_mask[l]) ref_mem[q_addr][l*LW +: LW] = q_data[l*LW +: LW];
                    m_last = win;
                end
            end
        end
        chk("m_ready0", r0_ready, e_r0);
        chk("m_ready1", r1_ready, e_r1);
        chk("m_csb0", csb0, e_csb);
        chk("m_web0", web0, e_web);
        chk("m_wmask0", wmask0, e_mask);
        chk("m_addr0", addr0, e_addr);
        chk("m_din0", din0, e_din);
        chk("m_rsp0", r0_rsp_valid, e_p0);
        chk("m_rsp1", r1_rsp_valid, e_p1);
        chk("m_rdata", rsp_rdata, m_rdata);
        chk("m_init_done", init_done, e_done);
    end

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic set0(input bit v, input bit we, input logic [AW-1:0] a,
                        input logic [NM-1:0] m, input logic [DW-1:0] d);
        r0_valid = v; r0_we = we; r0_addr = a; r0_wmask = m; r0_wdata = d;
    endtask

    task automatic set1(input bit v, input bit we, input logic [AW-1:0] a,
                        input logic [NM-1:0] m, input logic [DW-1:0] d);
        r1_valid = v; r1_we = we; r1_addr = a; r1_wmask = m; r1_wdata = d;
    endtask

    task automatic rand0();
        set0($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
             NM'($urandom), $urandom);
    endtask

    task automatic rand1();
        set1($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
             NM'($urandom), $urandom);
    endtask

    // Bounded wait for init_done; called at posedge+1, returns at posedge+1
    task automatic wait_init();
        int n;
        n = 0;
        do begin
            @(negedge clk0);
            n++;
        end while (init_done !== 1'b1 && n < DEPTH + 8);
        chk("init_cycles", n, INIT_EN ? DEPTH + 1 : 1);
        tick();
    endtask

    initial begin
        int busy;
        bit a0, a1;
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        sp_v  = 0;
        dout0 = '0;
        set0(0, 0, '0, '0, '0);
        set1(1, 1, 8'h07, '1, '0);

        // Reset state, with a request pending on r1
        repeat (2) @(negedge clk0);
        chk("rst_ready1", r1_ready, 0);
        chk("rst_csb0", csb0, 1);
        chk("rst_web0", web0, 1);
        chk("rst_rdata", rsp_rdata, 0);
        tick();
        set1(0, 0, '0, '0, '0);
        rst0 = 0;
        wait_init();

`ifdef SRAM_INIT_EN
        set0(1, 0, 8'hFF, '0, '0);
        tick();
        set0(0, 0, '0, '0, '0);
        tick();
        @(negedge clk0);
        chk("init_rd_pulse", r0_rsp_valid, 1);
        chk("init_rd_data", rsp_rdata, 32'h0);
        tick();
`endif

        set1(1, 1, 8'h05, 4'hF, 32'hDEADBEEF);
        tick();
        set1(1, 1, 8'h10, 4'hF, 32'hFFFFFFFF);
        tick();
        set1(0, 0, '0, '0, '0);
        tick();

        // Single read
        set0(1, 0, 8'h05, '0, '0);
        @(negedge clk0);
        chk("rd_ready0", r0_ready, 1);
        chk("rd_csb0", csb0, 0);
        chk("rd_addr0", addr0, 8'h05);
        tick();
        set0(0, 0, '0, '0, '0);
        @(negedge clk0);
        chk("rd_not_yet", r0_rsp_valid, 0);
        tick();
        @(negedge clk0);
        chk("rd_pulse", r0_rsp_valid, 1);
        chk("rd_data", rsp_rdata, 32'hDEADBEEF);
        chk("rd_other", r1_rsp_valid, 0);
        tick();
        @(negedge clk0);
        chk("rd_one_cycle", r0_rsp_valid, 0);
        tick();

        // Masked write then read of the same word on the next edge
        set1(1, 1, 8'h10, 4'b0101, 32'h11223344);
        tick();
        set1(0, 0, '0, '0, '0);
        set0(1, 0, 8'h10, '0, '0);
        tick();
        set0(0, 0, '0, '0, '0);
        @(negedge clk0);
        chk("wr_pulse", r1_rsp_valid, 1);
        chk("wr_keeps_rdata", rsp_rdata, 32'hDEADBEEF);
        tick();
        @(negedge clk0);
        chk("raw_pulse", r0_rsp_valid, 1);
        chk("raw_data", rsp_rdata, 32'hFF22FF44);
        tick();

        // Lone r1 grant leaves r0 favoured for the contention run
        set1(1, 0, 8'h03, '0, '0);
        tick();
        set1(0, 0, '0, '0, '0);
        set0(1, 0, 8'h01, '0, '0);
        set1(1, 0, 8'h02, '0, '0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk0);
            chk("cont_r0", r0_ready, (k % 2) == 0);
            chk("cont_r1", r1_ready, (k % 2) == 1);
            tick();
        end
        set0(0, 0, '0, '0, '0);
        set1(0, 0, '0, '0, '0);
        repeat (3) tick();

        // Idle
        busy = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk0);
            if (csb0 !== 1'b1 || web0 !== 1'b1 || r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0)
                busy++;
            tick();
        end
        chk("idle_quiet", busy, 0);

        // Reset with a read in flight
        set0(1, 0, 8'h05, '0, '0);
        tick();
        rst0 = 1;
        @(negedge clk0);
        chk("rst_mid_ready0", r0_ready, 0);
        chk("rst_mid_csb0", csb0, 1);
        chk("rst_mid_rdata", rsp_rdata, 0);
        chk("rst_mid_rsp0", r0_rsp_valid, 0);
        tick();
        set0(0, 0, '0, '0, '0);
        tick();
        rst0 = 0;
        wait_init();
        busy = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk0);
            if (r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0) busy++;
            tick();
        end
        chk("rst_no_pulse", busy, 0);

        // Random traffic; requests held until accepted
        rand0();
        rand1();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk0);
            a0 = r0_valid && r0_ready;
            a1 = r1_valid && r1_ready;
            tick();
            if (!r0_valid || a0) rand0();
            if (!r1_valid || a1) rand1();
        end
        set0(0, 0, '0, '0, '0);
        set1(0, 0, '0, '0, '0);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
